// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam int unsigned MEM_LAT_DEFAULT = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester/memory-side signal bundle of the memory port arbiter.
// slave: the arbiter's view; master: the requester/memory side driving it.
interface mem_port_arbiter_if;

    logic        req0;
    logic        req1;
    logic        we1;
    logic [31:0] mem_rdata;
    logic        mem_sel;
    logic        mem_en;
    logic        mem_we;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [31:0] rdata;
    logic        busy;

    modport slave (
        input  req0, req1, we1, mem_rdata,
        output mem_sel, mem_en, mem_we, gnt0, gnt1, done0, done1, rdata, busy
    );

    modport master (
        output req0, req1, we1, mem_rdata,
        input  mem_sel, mem_en, mem_we, gnt0, gnt1, done0, done1, rdata, busy
    );

endinterface

// File: rtl/mem_port_arbiter_arb_rr2.sv
// arb_rr2: combinational 2-way picker. Masked requests are dropped; on a tie the
// port that did not win last time is chosen.
// Build option: MEM_ARB_DATA_PRIORITY_EN makes the data port win every tie instead.
module mem_port_arbiter_arb_rr2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last_grant,
    output logic       winner,
    output logic       valid
);

    logic [1:0] cand;

    assign cand  = req & ~mask;
    assign valid = |cand;

`ifdef MEM_ARB_DATA_PRIORITY_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    // Fixed priority: data port beats fetch whenever it is a candidate.
    always_comb begin
        winner = PORT_FETCH;
        if (cand[PORT_DATA]) begin
            winner = PORT_DATA;
        end
    end
`else
    // Round-robin: a lone candidate wins, a tie goes to the port not granted last.
    always_comb begin
        winner = PORT_FETCH;
        if (cand == 2'b11) begin
            winner = ~last_grant;
        end else if (cand[PORT_DATA]) begin
            winner = PORT_DATA;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences one single-port memory between instruction fetch (port 0, read-only)
// and load/store data (port 1). All outputs are registered.
// Build option: MEM_ARB_DATA_PRIORITY_EN selects fixed data-port priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT,
    parameter int unsigned CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             mem_sel_q, mem_sel_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             busy_q, busy_d;

    logic [1:0] arb_mask;
    logic       arb_winner;
    logic       arb_valid;

    // In RESP the current owner's request is hidden so it cannot be re-granted.
    assign arb_mask = (state_q == ST_RESP) ? (mem_sel_q ? 2'b10 : 2'b01) : 2'b00;

    mem_port_arbiter_arb_rr2 u_arb (
        .req        ({bus.req1, bus.req0}),
        .mask       (arb_mask),
        .last_grant (last_grant_q),
        .winner     (arb_winner),
        .valid      (arb_valid)
    );

    // Next-state and next-output logic for the IDLE/ACCESS/RESP sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        mem_sel_d    = mem_sel_q;
        mem_en_d     = 1'b0;
        mem_we_d     = mem_we_q;
        gnt0_d       = gnt0_q;
        gnt1_d       = gnt1_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        rdata_d      = rdata_q;

        unique case (state_q)
            ST_ACCESS: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_RESP;
                    if (!mem_we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                    done0_d = ~mem_sel_q;
                    done1_d = mem_sel_q;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_IDLE, ST_RESP: begin
                if (arb_valid) begin
                    // Start a new access; mux select and write enable freeze here.
                    state_d      = ST_ACCESS;
                    cnt_d        = LAT_LOAD;
                    last_grant_d = arb_winner;
                    mem_sel_d    = arb_winner;
                    mem_en_d     = 1'b1;
                    mem_we_d     = arb_winner & bus.we1;
                    gnt0_d       = ~arb_winner;
                    gnt1_d       = arb_winner;
                end else begin
                    state_d  = ST_IDLE;
                    mem_we_d = 1'b0;
                    gnt0_d   = 1'b0;
                    gnt1_d   = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                mem_we_d = 1'b0;
                gnt0_d   = 1'b0;
                gnt1_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, counter and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            mem_sel_q    <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            mem_sel_q    <= mem_sel_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.mem_sel = mem_sel_q;
    assign bus.mem_en  = mem_en_q;
    assign bus.mem_we  = mem_we_q;
    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.done0   = done0_q;
    assign bus.done1   = done1_q;
    assign bus.rdata   = rdata_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LAT = 2 main instance, plus a
// MEM_LAT = 1 instance). The reference model tracks each access as a phase count
// since its grant.
module tb_mem_port_arbiter;

    localparam int LAT = 2;
`ifdef MEM_ARB_DATA_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic rst1_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    mem_port_arbiter_if bus ();
    mem_port_arbiter_if bus1 ();

    mem_port_arbiter #(.MEM_LAT(2), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mem_port_arbiter #(.MEM_LAT(1), .CNT_W(4)) dut1 (
        .clk   (clk),
        .rst_n (rst1_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = no owner, 1..LAT = access cycles, LAT+1 = response.
    int          m_phase;
    logic        m_owner;
    logic        m_last;
    logic        m_sel;
    logic        m_we;
    logic [31:0] m_rdata;

    task automatic model_reset();
        m_phase = 0;
        m_owner = 1'b0;
        m_last  = 1'b1;
        m_sel   = 1'b0;
        m_we    = 1'b0;
        m_rdata = 32'h0;
    endtask

    // Advance the model across one rising edge using the inputs now on the bus.
    task automatic model_edge();
        logic c0, c1, w;
        if (m_phase >= 1 && m_phase <= LAT) begin
            if (m_phase == LAT && !m_we) m_rdata = bus.mem_rdata;
            m_phase++;
        end else begin
            c0 = bus.req0 && !(m_phase == LAT + 1 && m_owner == 1'b0);
            c1 = bus.req1 && !(m_phase == LAT + 1 && m_owner == 1'b1);
            if (c0 || c1) begin
                if (c0 && c1) w = PRIO ? 1'b1 : ~m_last;
                else          w = c1;
                m_owner = w;
                m_last  = w;
                m_sel   = w;
                m_we    = w && bus.we1;
                m_phase = 1;
            end else begin
                m_phase = 0;
                m_we    = 1'b0;
            end
        end
    endtask

    function automatic logic [7:0] model_ctl();
        logic act, rsp;
        act = (m_phase != 0);
        rsp = (m_phase == LAT + 1);
        return {m_sel, m_phase == 1, m_we & act, act & ~m_owner, act & m_owner,
                rsp & ~m_owner, rsp & m_owner, act};
    endfunction

    function automatic logic [7:0] dut_ctl();
        return {bus.mem_sel, bus.mem_en, bus.mem_we, bus.gnt0, bus.gnt1,
                bus.done0, bus.done1, bus.busy};
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        bus.req0 = 1'b1;
        bus.req1 = 1'b0;
        bus.we1 = 1'b0;
        bus.mem_rdata = 32'hDEADBEEF;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dut_ctl(), bus.rdata} !== 40'd0) begin
            errors++;
            $display("FAIL reset_async got=%h want=0", {dut_ctl(), bus.rdata});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({dut_ctl(), bus.rdata} !== 40'd0) begin
            errors++;
            $display("FAIL reset_held got=%h want=0", {dut_ctl(), bus.rdata});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 1; c <= LAT + 2; c++) begin
            tick();
            checks++;
            if (dut_ctl() !== model_ctl()) begin
                errors++;
                $display("FAIL reset_ctl cyc=%0d got=%b want=%b", cyc, dut_ctl(), model_ctl());
            end
            checks++;
            if (bus.rdata !== m_rdata) begin
                errors++;
                $display("FAIL reset_rdata cyc=%0d got=%h want=%h", cyc, bus.rdata, m_rdata);
            end
            if (c == 1) begin
                checks++;
                if (!(bus.gnt0 === 1'b1 && bus.mem_en === 1'b1 && bus.mem_sel === 1'b0)) begin
                    errors++;
                    $display("FAIL reset_first_grant gnt0=%b en=%b sel=%b want 1 1 0",
                             bus.gnt0, bus.mem_en, bus.mem_sel);
                end
            end
            if (c == LAT + 1) begin
                checks++;
                if (bus.done0 !== 1'b1 || bus.rdata !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL reset_done0 done0=%b rdata=%h want 1 deadbeef",
                             bus.done0, bus.rdata);
                end
            end
        end
        bus.req0 = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic grants[$];
        do_reset();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.we1 = 1'b0;
        for (int c = 0; c < 6 * (LAT + 1); c++) begin
            bus.mem_rdata = $urandom;
            tick();
            checks++;
            if (dut_ctl() !== model_ctl()) begin
                errors++;
                $display("FAIL simul_ctl cyc=%0d got=%b want=%b", cyc, dut_ctl(), model_ctl());
            end
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL simul_bubble cyc=%0d busy=%b want 1", cyc, bus.busy);
            end
            if (bus.mem_en === 1'b1) grants.push_back(bus.mem_sel);
        end
        checks++;
        if (grants.size() != 6) begin
            errors++;
            $display("FAIL simul_count got=%0d want=6", grants.size());
        end else begin
            checks++;
            if (grants[0] !== PRIO) begin
                errors++;
                $display("FAIL simul_first got=%b want=%b", grants[0], PRIO);
            end
            for (int i = 1; i < 6; i++) begin
                checks++;
                if (grants[i] === grants[i-1]) begin
                    errors++;
                    $display("FAIL simul_alternate idx=%0d got=%b want=%b",
                             i, grants[i], ~grants[i-1]);
                end
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            tick();
            checks++;
            if (dut_ctl() !== model_ctl()) begin
                errors++;
                $display("FAIL simul_drain cyc=%0d got=%b want=%b", cyc, dut_ctl(), model_ctl());
            end
        end
    endtask

    task automatic test_write();
        int nwe;
        int ndone;
        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        bus.we1 = 1'b0;
        bus.mem_rdata = 32'h12345678;
        for (int c = 0; c < LAT + 2; c++) begin
            tick();
            checks++;
            if (dut_ctl() !== model_ctl()) begin
                errors++;
                $display("FAIL wr_pre_ctl cyc=%0d got=%b want=%b", cyc, dut_ctl(), model_ctl());
            end
            if (bus.done1 === 1'b1) bus.req1 = 1'b0;
        end
        checks++;
        if (bus.rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL wr_pre_rdata got=%h want=12345678", bus.rdata);
        end
        nwe = 0;
        ndone = 0;
        bus.req1 = 1'b1;
        bus.we1 = 1'b1;
        bus.mem_rdata = 32'hFFFF0000;
        for (int c = 0; c < LAT + 2; c++) begin
            tick();
            bus.we1 = 1'b0;
            checks++;
            if (dut_ctl() !== model_ctl()) begin
                errors++;
                $display("FAIL wr_ctl cyc=%0d got=%b want=%b", cyc, dut_ctl(), model_ctl());
            end
            if (bus.mem_we === 1'b1 && bus.mem_sel === 1'b1 && bus.gnt1 === 1'b1) nwe++;
            if (bus.done1 === 1'b1) begin
                ndone++;
                bus.req1 = 1'b0;
            end
        end
        checks++;
        if (nwe != LAT + 1 || ndone != 1) begin
            errors++;
            $display("FAIL wr_we_cycles we=%0d done=%0d want %0d 1", nwe, ndone, LAT + 1);
        end
        checks++;
        if (bus.rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL wr_rdata_kept got=%h want=12345678", bus.rdata);
        end
    endtask

    task automatic test_mid_drop();
        bus.req0 = 1'b1;
        bus.req1 = 1'b0;
        bus.mem_rdata = 32'hA5A5_0F0F;
        for (int c = 1; c <= LAT + 2; c++) begin
            tick();
            if (c == 2) bus.req0 = 1'b0;
            checks++;
            if (dut_ctl() !== model_ctl()) begin
                errors++;
                $display("FAIL drop_ctl cyc=%0d got=%b want=%b", cyc, dut_ctl(), model_ctl());
            end
            if (c == LAT + 1) begin
                checks++;
                if (bus.done0 !== 1'b1 || bus.rdata !== 32'hA5A5_0F0F) begin
                    errors++;
                    $display("FAIL drop_done0 done0=%b rdata=%h want 1 a5a50f0f",
                             bus.done0, bus.rdata);
                end
            end
            if (c == LAT + 2) begin
                checks++;
                if (bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_idle busy=%b want 0", bus.busy);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        bus.we1 = 1'b0;
        bus.mem_rdata = $urandom;
        tick();
        checks++;
        if (dut_ctl() !== model_ctl()) begin
            errors++;
            $display("FAIL areset_pre cyc=%0d got=%b want=%b", cyc, dut_ctl(), model_ctl());
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dut_ctl(), bus.rdata} !== 40'd0) begin
            errors++;
            $display("FAIL areset_clear got=%h want=0", {dut_ctl(), bus.rdata});
        end
        for (int c = 0; c < LAT + 2; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.done1 !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL areset_no_done done1=%b busy=%b want 0 0", bus.done1, bus.busy);
            end
        end
        bus.req1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick();
        checks++;
        if ({dut_ctl(), bus.rdata} !== {model_ctl(), m_rdata}) begin
            errors++;
            $display("FAIL areset_after got=%h want=%h", {dut_ctl(), bus.rdata},
                     {model_ctl(), m_rdata});
        end
    endtask

    task automatic test_lat1();
        bus1.req0 = 1'b0;
        bus1.req1 = 1'b0;
        bus1.we1 = 1'b0;
        bus1.mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        rst1_n = 1'b1;
        bus1.req1 = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus1.mem_en, bus1.gnt1, bus1.mem_sel, bus1.done1} !== 4'b1110) begin
            errors++;
            $display("FAIL lat1_access en,gnt1,sel,done1=%b want 1110",
                     {bus1.mem_en, bus1.gnt1, bus1.mem_sel, bus1.done1});
        end
        bus1.mem_rdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        checks++;
        if ({bus1.mem_en, bus1.gnt1, bus1.done1} !== 3'b011 || bus1.rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL lat1_resp en,gnt1,done1=%b rdata=%h want 011 cafef00d",
                     {bus1.mem_en, bus1.gnt1, bus1.done1}, bus1.rdata);
        end
        bus1.req1 = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus1.busy, bus1.gnt1, bus1.done1} !== 3'b000 || bus1.rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL lat1_idle busy,gnt1,done1=%b rdata=%h want 000 cafef00d",
                     {bus1.busy, bus1.gnt1, bus1.done1}, bus1.rdata);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bus.mem_rdata = $urandom;
            bus.we1 = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (dut_ctl() !== model_ctl()) begin
                errors++;
                $display("FAIL rand_ctl cyc=%0d got=%b want=%b", cyc, dut_ctl(), model_ctl());
            end
            checks++;
            if (bus.rdata !== m_rdata) begin
                errors++;
                $display("FAIL rand_rdata cyc=%0d got=%h want=%h", cyc, bus.rdata, m_rdata);
            end
            if (bus.done0 === 1'b1) bus.req0 = 1'($urandom_range(0, 1));
            else if (!bus.req0) bus.req0 = ($urandom_range(0, 2) == 0);
            if (bus.done1 === 1'b1) bus.req1 = 1'($urandom_range(0, 1));
            else if (!bus.req1) bus.req1 = ($urandom_range(0, 2) == 0);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        for (int c = 0; c < 2 * (LAT + 1) + 2; c++) begin
            tick();
            checks++;
            if ({dut_ctl(), bus.rdata} !== {model_ctl(), m_rdata}) begin
                errors++;
                $display("FAIL rand_drain cyc=%0d got=%h want=%h", cyc,
                         {dut_ctl(), bus.rdata}, {model_ctl(), m_rdata});
            end
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rand_final_idle busy=%b want 0", bus.busy);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        rst1_n = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.we1 = 1'b0;
        bus.mem_rdata = 32'h0;
        bus1.req0 = 1'b0;
        bus1.req1 = 1'b0;
        bus1.we1 = 1'b0;
        bus1.mem_rdata = 32'h0;
        model_reset();
        #1;
        rst1_n = 1'b0;
        test_reset();
        test_simultaneous();
        test_write();
        test_mid_drop();
        test_async_reset();
        test_lat1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule
